// File: rtl/wm_level_timer.sv
// Drum water-level model and wash/spin phase timers; turns the washing-machine
// controller's actuator outputs back into its sensor inputs.
module wm_level_timer #(
   parameter int TICK_DIV    = 10,
   parameter int CYCLE_TICKS = 20,
   parameter int SPIN_TICKS  = 8,
   parameter int LEVEL_MAX   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fill_valve_on,
   input  logic       drain_valve_on,
   input  logic       motor_on,
   input  logic       door_lock,
   output logic       filled,
   output logic       drained,
   output logic       cycle_time_out,
   output logic       spin_time_out,
   output logic [7:0] level
);

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [15:0] CYC_MAX   = 16'(CYCLE_TICKS);
   localparam logic [15:0] SPIN_MAX  = 16'(SPIN_TICKS);
   localparam logic [7:0]  LVL_MAX   = 8'(LEVEL_MAX);

   logic [15:0] prescale_r;
   logic [15:0] prescale_next_s;
   logic        tick_s;
   logic [7:0]  level_r;
   logic [7:0]  level_next_s;
   logic [15:0] cycle_cnt_r;
   logic [15:0] cycle_next_s;
   logic [15:0] spin_cnt_r;
   logic [15:0] spin_next_s;
   logic        spin_en_s;
   logic        filled_r;
   logic        drained_r;
   logic        cycle_to_r;
   logic        spin_to_r;

   // Free-running prescaler; tick marks its last count.
   always_comb begin
      tick_s          = 1'b0;
      prescale_next_s = prescale_r;
      if (prescale_r == TICK_LAST) begin
         tick_s          = 1'b1;
         prescale_next_s = 16'd0;
      end else begin
         tick_s          = 1'b0;
         prescale_next_s = prescale_r + 16'd1;
      end
   end

   // Water level: moves one unit per tick when exactly one valve is open.
   always_comb begin
      level_next_s = level_r;
      if (tick_s) begin
         case ({fill_valve_on, drain_valve_on})
            2'b10: begin
               if (level_r < LVL_MAX) begin
                  level_next_s = level_r + 8'd1;
               end else begin
                  level_next_s = level_r;
               end
            end
            2'b01: begin
               if (level_r != 8'd0) begin
                  level_next_s = level_r - 8'd1;
               end else begin
                  level_next_s = level_r;
               end
            end
            default: level_next_s = level_r;
         endcase
      end else begin
         level_next_s = level_r;
      end
   end

   // Wash timer: clear wins over a coincident tick.
   always_comb begin
      cycle_next_s = cycle_cnt_r;
      if (!motor_on || !door_lock) begin
         cycle_next_s = 16'd0;
      end else if (tick_s && (cycle_cnt_r != CYC_MAX)) begin
         cycle_next_s = cycle_cnt_r + 16'd1;
      end else begin
         cycle_next_s = cycle_cnt_r;
      end
   end

   // Spin timer: only runs once the drum is already empty, so draining never counts as spin.
   always_comb begin
      spin_en_s   = drain_valve_on && !fill_valve_on && door_lock && (level_r == 8'd0);
      spin_next_s = spin_cnt_r;
      if (!spin_en_s) begin
         spin_next_s = 16'd0;
      end else if (tick_s && (spin_cnt_r != SPIN_MAX)) begin
         spin_next_s = spin_cnt_r + 16'd1;
      end else begin
         spin_next_s = spin_cnt_r;
      end
   end

   // State registers; flags are registered from next-state so no input reaches an output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prescale_r  <= 16'd0;
         level_r     <= 8'd0;
         cycle_cnt_r <= 16'd0;
         spin_cnt_r  <= 16'd0;
         filled_r    <= 1'b0;
         drained_r   <= 1'b1;
         cycle_to_r  <= 1'b0;
         spin_to_r   <= 1'b0;
      end else begin
         prescale_r  <= prescale_next_s;
         level_r     <= level_next_s;
         cycle_cnt_r <= cycle_next_s;
         spin_cnt_r  <= spin_next_s;
         filled_r    <= (level_next_s == LVL_MAX);
         drained_r   <= (level_next_s == 8'd0);
         cycle_to_r  <= (cycle_next_s == CYC_MAX);
         spin_to_r   <= (spin_next_s == SPIN_MAX);
      end
   end

   assign filled         = filled_r;
   assign drained        = drained_r;
   assign cycle_time_out = cycle_to_r;
   assign spin_time_out  = spin_to_r;
   assign level          = level_r;

endmodule

// File: tb/tb_wm_level_timer.sv
// Bench for wm_level_timer: directed phase checks with hand-computed clock numbers,
// then randomized actuator segments against a tick-counting behavioural model.
module tb_wm_level_timer;

   localparam int TICK_DIV    = 10;
   localparam int CYCLE_TICKS = 20;
   localparam int SPIN_TICKS  = 8;
   localparam int LEVEL_MAX   = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       fill_valve_on = 1'b0;
   logic       drain_valve_on = 1'b0;
   logic       motor_on = 1'b0;
   logic       door_lock = 1'b0;
   logic       filled;
   logic       drained;
   logic       cycle_time_out;
   logic       spin_time_out;
   logic [7:0] level;

   int n_vec = 0;
   int n_err = 0;

   // Model: water units, ticks spent washing, ticks spent spinning, clocks since reset release.
   int m_n     = 0;
   int m_level = 0;
   int m_wash  = 0;
   int m_spin  = 0;

   wm_level_timer #(
      .TICK_DIV(TICK_DIV), .CYCLE_TICKS(CYCLE_TICKS),
      .SPIN_TICKS(SPIN_TICKS), .LEVEL_MAX(LEVEL_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
      .motor_on(motor_on), .door_lock(door_lock),
      .filled(filled), .drained(drained),
      .cycle_time_out(cycle_time_out), .spin_time_out(spin_time_out),
      .level(level)
   );

   always #5 clk = ~clk;

   task automatic model_edge();
      bit tick;
      bit spinning;
      tick     = ((m_n % TICK_DIV) == TICK_DIV - 1);
      spinning = drain_valve_on && !fill_valve_on && door_lock && (m_level == 0);
      if (tick && fill_valve_on && !drain_valve_on) m_level = (m_level < LEVEL_MAX) ? m_level + 1 : LEVEL_MAX;
      else if (tick && drain_valve_on && !fill_valve_on) m_level = (m_level > 0) ? m_level - 1 : 0;
      if (!motor_on || !door_lock) m_wash = 0;
      else if (tick) m_wash = (m_wash + 1 > CYCLE_TICKS) ? CYCLE_TICKS : m_wash + 1;
      if (!spinning) m_spin = 0;
      else if (tick) m_spin = (m_spin + 1 > SPIN_TICKS) ? SPIN_TICKS : m_spin + 1;
      m_n++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at clock %0d: got %0d, expected %0d", name, m_n, act, exp);
      end
   endtask

   task automatic compare_model();
      n_vec++;
      if (level !== 8'(m_level) || filled !== (m_level == LEVEL_MAX) || drained !== (m_level == 0) ||
          cycle_time_out !== (m_wash == CYCLE_TICKS) || spin_time_out !== (m_spin == SPIN_TICKS)) begin
         n_err++;
         $display("FAIL model clock %0d: got lvl=%0d f=%b d=%b cto=%b sto=%b, expected lvl=%0d f=%b d=%b cto=%b sto=%b",
                  m_n, level, filled, drained, cycle_time_out, spin_time_out, m_level,
                  (m_level == LEVEL_MAX), (m_level == 0), (m_wash == CYCLE_TICKS), (m_spin == SPIN_TICKS));
      end
      if (cycle_time_out && spin_time_out) begin
         n_err++;
         $display("FAIL both_timeouts at clock %0d: got 1/1, expected at most one", m_n);
      end
   endtask

   // One clock: model follows the edge with the same inputs, outputs compared on the falling edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_model();
   endtask

   // Called on a falling edge; asserts reset between edges and releases it a clock later.
   task automatic do_reset();
      #2;
      reset   = 1'b0;
      m_level = 0;
      m_wash  = 0;
      m_spin  = 0;
      m_n     = 0;
      #1;
      check("reset_level", int'(level), 0);
      check("reset_drained", int'(drained), 1);
      check("reset_filled", int'(filled), 0);
      check("reset_cto", int'(cycle_time_out), 0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic set_in(input bit f, input bit d, input bit m, input bit l);
      fill_valve_on  = f;
      drain_valve_on = d;
      motor_on       = m;
      door_lock      = l;
   endtask

   initial begin
      int first_drained;
      @(negedge clk);
      do_reset();

      // Idle after reset: nothing moves.
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (25) step();
      check("idle_level", int'(level), 0);
      check("idle_drained", int'(drained), 1);

      // Fill from reset release: level steps on clocks 10,20,..,50.
      @(negedge clk);
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      while (m_n < 60) begin
         step();
         if (m_n == 9)  check("fill_lvl_c9", int'(level), 0);
         if (m_n == 10) check("fill_lvl_c10", int'(level), 1);
         if (m_n == 49) check("fill_filled_c49", int'(filled), 0);
         if (m_n == 50) check("fill_filled_c50", int'(filled), 1);
         if (m_n == 60) check("fill_lvl_c60", int'(level), 5);
      end

      // Wash from clock 61: 20 ticks land on clock 260.
      set_in(1'b0, 1'b0, 1'b1, 1'b1);
      while (!cycle_time_out && m_n < 460) step();
      check("wash_timeout_clock", m_n, 260);
      set_in(1'b0, 1'b1, 1'b0, 1'b1);
      step();
      check("wash_timeout_pulse", int'(cycle_time_out), 0);

      // Drain from clock 261: empty at 310, then 8 spin ticks ending at 390.
      first_drained = -1;
      while (!spin_time_out && m_n < 700) begin
         step();
         if (drained && first_drained < 0) first_drained = m_n;
      end
      check("drained_clock", first_drained, 310);
      check("spin_timeout_clock", m_n, 390);

      // Reset mid-wash at level 3 with 12 wash ticks accumulated.
      @(negedge clk);
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b1);
      while (m_n < 30) step();
      check("midwash_lvl3", int'(level), 3);
      set_in(1'b0, 1'b0, 1'b1, 1'b1);
      while (m_n < 150) step();
      check("midwash_no_to", int'(cycle_time_out), 0);
      do_reset();
      while (!cycle_time_out && m_n < 400) step();
      check("postreset_wash_clock", m_n, 200);

      // Motor dropped after 10 ticks, then reasserted: full 20 ticks again.
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      step();
      set_in(1'b0, 1'b0, 1'b1, 1'b1);
      while (m_n < 300) step();
      set_in(1'b0, 1'b0, 1'b0, 1'b1);
      while (m_n < 304) step();
      set_in(1'b0, 1'b0, 1'b1, 1'b1);
      while (!cycle_time_out && m_n < 800) step();
      check("restart_wash_clock", m_n, 500);

      // Randomized actuator segments, occasional mid-run reset.
      for (int seg = 0; seg < 60; seg++) begin
         int len;
         bit lk;
         lk  = (($urandom % 8) != 0);
         len = int'($urandom_range(1, 260));
         case ($urandom % 6)
            0: set_in(1'b1, 1'b0, 1'b0, lk);
            1: set_in(1'b0, 1'b1, 1'b0, lk);
            2: set_in(1'b0, 1'b0, 1'b1, lk);
            3: set_in(1'b1, 1'b1, 1'b0, lk);
            4: set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            default: set_in(1'b0, 1'b0, 1'b0, lk);
         endcase
         repeat (len) step();
         if (($urandom % 20) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
